// File: rtl/pzbcm_sram_pkg.sv
// Shared helpers and parameter bundle for the pzbcm SRAM access blocks.
package pzbcm_sram_pkg;

   typedef struct packed {
      int channels;
      int words;
      int data_width;
      int banks;
      int bank_lsb;
      int read_latency;
   } pzbcm_sram_params;

   function automatic int calc_pointer_width(input int n);
      return (n <= 32'sd1) ? 32'sd1 : $clog2(n);
   endfunction

   function automatic int calc_bank_width(input int banks);
      return calc_pointer_width(banks);
   endfunction

   function automatic int calc_ram_words(input int words, input int banks);
      return words / banks;
   endfunction

   function automatic int calc_ram_pointer_width(input int words, input int banks);
      return calc_pointer_width(calc_ram_words(words, banks));
   endfunction

   // Contiguous mapping needs the address width to locate the bank field at the top.
   function automatic int get_bank_index(input int address, input int banks, input int bank_lsb,
                                         input int address_width);
      int shift;
      shift = address_width - calc_bank_width(banks);
      if (banks <= 32'sd1) return 32'sd0;
      else if (bank_lsb != 32'sd0) return address % banks;
      else return (address >> shift) % banks;
   endfunction

   function automatic int get_row_index(input int address, input int banks, input int bank_lsb,
                                        input int address_width);
      if (banks <= 32'sd1) return address;
      else if (bank_lsb != 32'sd0) return address / banks;
      else return address % (32'sd1 << (address_width - calc_bank_width(banks)));
   endfunction

endpackage

// File: rtl/pzbcm_sram_bank.sv
// Behavioural single-port RAM bank with a fixed-latency read data pipeline.
module pzbcm_sram_bank
   import pzbcm_sram_pkg::*;
#(
   parameter int WORDS        = 256,
   parameter int DATA_WIDTH   = 32,
   parameter int READ_LATENCY = 1,
   localparam int AW          = calc_pointer_width(WORDS)
)(
   input  logic                  i_clk,
   input  logic                  i_valid,
   input  logic                  i_write,
   input  logic [AW-1:0]         i_address,
   input  logic [DATA_WIDTH-1:0] i_data,
   output logic [DATA_WIDTH-1:0] o_data
);

   logic [DATA_WIDTH-1:0] ram_r  [WORDS];
   logic [DATA_WIDTH-1:0] pipe_r [READ_LATENCY];

   // Array update or read capture at the acceptance edge, then shift the read pipeline
   always_ff @(posedge i_clk) begin
      if (i_valid && i_write) begin
         ram_r[i_address] <= i_data;
      end else if (i_valid) begin
         pipe_r[0] <= ram_r[i_address];
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
         pipe_r[i] <= pipe_r[i-1];
      end
   end

   assign o_data = pipe_r[READ_LATENCY-1];

endmodule

// File: rtl/pzbcm_sram_banked_access.sv
// Multi-channel front end arbitrating requests round-robin onto independent single-port SRAM banks.
module pzbcm_sram_banked_access
   import pzbcm_sram_pkg::*;
#(
   parameter int CHANNELS     = 2,
   parameter int WORDS        = 1024,
   parameter int DATA_WIDTH   = 32,
   parameter int BANKS        = 4,
   parameter int BANK_LSB     = 1,
   parameter int READ_LATENCY = 1,
   localparam int AW          = calc_pointer_width(WORDS)
)(
   input  logic                                i_clk,
   input  logic                                i_rst_n,
   input  logic [CHANNELS-1:0]                 i_req_valid,
   output logic [CHANNELS-1:0]                 o_req_ready,
   input  logic [CHANNELS-1:0]                 i_req_write,
   input  logic [CHANNELS-1:0][AW-1:0]         i_req_address,
   input  logic [CHANNELS-1:0][DATA_WIDTH-1:0] i_req_data,
   output logic [CHANNELS-1:0]                 o_rsp_valid,
   output logic [CHANNELS-1:0][DATA_WIDTH-1:0] o_rsp_data
);

   localparam int BW        = calc_bank_width(BANKS);
   localparam int RAM_WORDS = calc_ram_words(WORDS, BANKS);
   localparam int RAW       = calc_ram_pointer_width(WORDS, BANKS);
   localparam int CW        = calc_pointer_width(CHANNELS);

   logic [CHANNELS-1:0][BW-1:0]                    bank_s;
   logic [CHANNELS-1:0][RAW-1:0]                   row_s;
   logic [BANKS-1:0][CHANNELS-1:0]                 grant_s;
   logic [BANKS-1:0][CW-1:0]                       winner_s;
   logic [BANKS-1:0]                               bank_valid_s;
   logic [BANKS-1:0]                               bank_write_s;
   logic [BANKS-1:0][RAW-1:0]                      bank_row_s;
   logic [BANKS-1:0][DATA_WIDTH-1:0]               bank_wdata_s;
   logic [BANKS-1:0][DATA_WIDTH-1:0]               bank_rdata_s;
   logic [BANKS-1:0][CW-1:0]                       pointer_r;
   logic [CHANNELS-1:0][READ_LATENCY-1:0]          rsp_valid_r;
   logic [CHANNELS-1:0][READ_LATENCY-1:0][BW-1:0]  rsp_bank_r;

   // Split each channel address into its bank index and the row inside that bank
   always_comb begin
      bank_s = '0;
      row_s  = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         bank_s[c] = BW'(get_bank_index(int'(i_req_address[c]), BANKS, BANK_LSB, AW));
         row_s[c]  = RAW'(get_row_index(int'(i_req_address[c]), BANKS, BANK_LSB, AW));
      end
   end

   // Per-bank round-robin search from the priority pointer; first hit wins the bank
   always_comb begin
      int   ch;
      logic hit;
      ch           = 0;
      hit          = 1'b0;
      grant_s      = '0;
      winner_s     = '0;
      bank_valid_s = '0;
      bank_write_s = '0;
      bank_row_s   = '0;
      bank_wdata_s = '0;
      o_req_ready  = '0;
      for (int b = 0; b < BANKS; b++) begin
         for (int k = 0; k < CHANNELS; k++) begin
            ch  = (int'(pointer_r[b]) + k) % CHANNELS;
            hit = !bank_valid_s[b] && i_rst_n && i_req_valid[ch] && (int'(bank_s[ch]) == b);
            grant_s[b][ch]  = hit;
            winner_s[b]     = hit ? CW'(ch) : winner_s[b];
            bank_valid_s[b] = bank_valid_s[b] | hit;
         end
         bank_write_s[b] = i_req_write[winner_s[b]];
         bank_row_s[b]   = row_s[winner_s[b]];
         bank_wdata_s[b] = i_req_data[winner_s[b]];
         o_req_ready     = o_req_ready | grant_s[b];
      end
   end

   // Move each bank's pointer just past its latest winner; hold when the bank is idle
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pointer_r <= '0;
      end else begin
         for (int b = 0; b < BANKS; b++) begin
            if (bank_valid_s[b]) begin
               pointer_r[b] <= CW'((int'(winner_s[b]) + 32'sd1) % CHANNELS);
            end
         end
      end
   end

   // Per-channel read tracker aligned with the bank output pipelines
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rsp_valid_r <= '0;
         rsp_bank_r  <= '0;
      end else begin
         for (int c = 0; c < CHANNELS; c++) begin
            rsp_valid_r[c][0] <= o_req_ready[c] && !i_req_write[c];
            rsp_bank_r[c][0]  <= bank_s[c];
            for (int s = 1; s < READ_LATENCY; s++) begin
               rsp_valid_r[c][s] <= rsp_valid_r[c][s-1];
               rsp_bank_r[c][s]  <= rsp_bank_r[c][s-1];
            end
         end
      end
   end

   // Route the matching bank's read data back to each channel
   always_comb begin
      o_rsp_valid = '0;
      o_rsp_data  = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         o_rsp_valid[c] = rsp_valid_r[c][READ_LATENCY-1];
         o_rsp_data[c]  = bank_rdata_s[rsp_bank_r[c][READ_LATENCY-1]];
      end
   end

   for (genvar b = 0; b < BANKS; b++) begin : g_bank
      pzbcm_sram_bank #(
         .WORDS        (RAM_WORDS),
         .DATA_WIDTH   (DATA_WIDTH),
         .READ_LATENCY (READ_LATENCY)
      ) u_bank (
         .i_clk     (i_clk),
         .i_valid   (bank_valid_s[b]),
         .i_write   (bank_write_s[b]),
         .i_address (bank_row_s[b]),
         .i_data    (bank_wdata_s[b]),
         .o_data    (bank_rdata_s[b])
      );
   end

endmodule

// File: tb/tb_pzbcm_sram_banked_access.sv
// Directed bench: interleaved RL=2 instance (dut_l) and contiguous RL=3 instance (dut_m) on shared stimulus.
module tb_pzbcm_sram_banked_access;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic [1:0]       req_valid = '0;
   logic [1:0]       req_write = '0;
   logic [1:0][9:0]  req_address = '0;
   logic [1:0][31:0] req_data = '0;
   logic [1:0]       l_ready, l_rsp_valid, m_ready, m_rsp_valid;
   logic [1:0][31:0] l_rsp_data, m_rsp_data;
   int               checks = 0;
   int               errors = 0;

   always #5 clk = ~clk;

   pzbcm_sram_banked_access #(
      .CHANNELS(2), .WORDS(1024), .DATA_WIDTH(32), .BANKS(4), .BANK_LSB(1), .READ_LATENCY(2)
   ) dut_l (
      .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(l_ready),
      .i_req_write(req_write), .i_req_address(req_address), .i_req_data(req_data),
      .o_rsp_valid(l_rsp_valid), .o_rsp_data(l_rsp_data)
   );

   pzbcm_sram_banked_access #(
      .CHANNELS(2), .WORDS(1024), .DATA_WIDTH(32), .BANKS(4), .BANK_LSB(0), .READ_LATENCY(3)
   ) dut_m (
      .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(m_ready),
      .i_req_write(req_write), .i_req_address(req_address), .i_req_data(req_data),
      .o_rsp_valid(m_rsp_valid), .o_rsp_data(m_rsp_data)
   );

   function automatic logic [31:0] pat(input int a);
      return 32'hA5A5_0000 | 32'(a);
   endfunction

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic drive(input int ch, input logic valid, input logic write, input int addr,
                        input logic [31:0] data);
      req_valid[ch]   = valid;
      req_write[ch]   = write;
      req_address[ch] = 10'(addr);
      req_data[ch]    = data;
   endtask

   task automatic idle();
      req_valid = '0;
      req_write = '0;
   endtask

   task automatic reset_pulse();
      @(negedge clk);
      idle();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      // reset: ready masked even with requests pending
      #1 rst_n = 1'b0;
      drive(0, 1'b1, 1'b0, 0, 32'd0);
      drive(1, 1'b1, 1'b0, 1, 32'd0);
      @(negedge clk); #1;
      check("reset_ready_l", 32'(l_ready), 32'd0);
      check("reset_ready_m", 32'(m_ready), 32'd0);
      check("reset_rsp_valid_l", 32'(l_rsp_valid), 32'd0);
      check("reset_rsp_valid_m", 32'(m_rsp_valid), 32'd0);
      @(negedge clk);
      idle();
      rst_n = 1'b1;

      // write 0xDEADBEEF @5 on ch0, read @5 on ch1
      @(negedge clk);
      drive(0, 1'b1, 1'b1, 5, 32'hDEADBEEF);
      #1;
      check("wr5_ready_l", 32'(l_ready), 32'd1);
      check("wr5_ready_m", 32'(m_ready), 32'd1);
      @(negedge clk);
      idle();
      drive(1, 1'b1, 1'b0, 5, 32'd0);
      #1;
      check("rd5_ready_l", 32'(l_ready), 32'd2);
      check("rd5_write_no_rsp_l", 32'(l_rsp_valid), 32'd0);
      @(negedge clk);
      idle();
      #1;
      check("rd5_lat1_l", 32'(l_rsp_valid), 32'd0);
      @(negedge clk); #1;
      check("rd5_lat2_valid_l", 32'(l_rsp_valid), 32'd2);
      check("rd5_lat2_data_l", l_rsp_data[1], 32'hDEADBEEF);
      check("rd5_lat2_valid_m", 32'(m_rsp_valid), 32'd0);
      @(negedge clk); #1;
      check("rd5_single_pulse_l", 32'(l_rsp_valid), 32'd0);
      check("rd5_lat3_valid_m", 32'(m_rsp_valid), 32'd2);
      check("rd5_lat3_data_m", m_rsp_data[1], 32'hDEADBEEF);
      @(negedge clk); #1;
      check("rd5_single_pulse_m", 32'(m_rsp_valid), 32'd0);

      // fill addresses 0..15 with a known pattern
      for (int a = 0; a < 16; a++) begin
         @(negedge clk);
         idle();
         drive(0, 1'b1, 1'b1, a, pat(a));
         #1;
         check("fill_ready_l", 32'(l_ready), 32'd1);
      end

      // same-cycle reads to addr 0 and 1: separate banks in dut_l, conflict in dut_m
      reset_pulse();
      @(negedge clk);
      drive(0, 1'b1, 1'b0, 0, 32'd0);
      drive(1, 1'b1, 1'b0, 1, 32'd0);
      #1;
      check("par_ready_l", 32'(l_ready), 32'd3);
      check("par_ready_m", 32'(m_ready), 32'd1);
      @(negedge clk);
      idle();
      @(negedge clk); #1;
      check("par_rsp_valid_l", 32'(l_rsp_valid), 32'd3);
      check("par_rsp_data0_l", l_rsp_data[0], pat(0));
      check("par_rsp_data1_l", l_rsp_data[1], pat(1));
      @(negedge clk); #1;
      check("par_rsp_valid_m", 32'(m_rsp_valid), 32'd1);
      check("par_rsp_data0_m", m_rsp_data[0], pat(0));

      // held conflicting reads to addr 4 and 8 alternate grants starting at ch0
      reset_pulse();
      for (int k = 0; k < 11; k++) begin
         @(negedge clk);
         idle();
         if (k < 8) begin
            drive(0, 1'b1, 1'b0, 4, 32'd0);
            drive(1, 1'b1, 1'b0, 8, 32'd0);
         end
         #1;
         if (k < 8) begin
            check("rr_ready_l", 32'(l_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
            check("rr_ready_m", 32'(m_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
         end
         if (k >= 2 && k < 10) begin
            check("rr_rsp_valid_l", 32'(l_rsp_valid), (k % 2 == 0) ? 32'd1 : 32'd2);
            check("rr_rsp_data_l", (k % 2 == 0) ? l_rsp_data[0] : l_rsp_data[1],
                  (k % 2 == 0) ? pat(4) : pat(8));
         end
      end

      // contiguous mapping: addr 256 is bank 1 row 0 and must not alias addr 0
      @(negedge clk);
      idle();
      drive(0, 1'b1, 1'b1, 256, 32'hBAD00256);
      #1;
      check("msb_wr256_ready_m", 32'(m_ready), 32'd1);
      @(negedge clk);
      idle();
      drive(0, 1'b1, 1'b0, 0, 32'd0);
      drive(1, 1'b1, 1'b0, 256, 32'd0);
      #1;
      check("msb_rd_ready_m", 32'(m_ready), 32'd3);
      @(negedge clk);
      idle();
      @(negedge clk);
      @(negedge clk); #1;
      check("msb_rsp_valid_m", 32'(m_rsp_valid), 32'd3);
      check("msb_addr0_data_m", m_rsp_data[0], pat(0));
      check("msb_addr256_data_m", m_rsp_data[1], 32'hBAD00256);

      // stream 16 reads on ch0
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         idle();
         if (i < 16) drive(0, 1'b1, 1'b0, i, 32'd0);
         #1;
         check("stream_ready_l", 32'(l_ready), (i < 16) ? 32'd1 : 32'd0);
         check("stream_valid_l", 32'(l_rsp_valid), (i >= 2 && i < 18) ? 32'd1 : 32'd0);
         if (i >= 2 && i < 18) check("stream_data_l", l_rsp_data[0], pat(i - 2));
         check("stream_valid_m", 32'(m_rsp_valid), (i >= 3 && i < 19) ? 32'd1 : 32'd0);
         if (i >= 3 && i < 19) check("stream_data_m", m_rsp_data[0], pat(i - 3));
      end

      // reset one cycle after a read is accepted drops the response and clears pointers
      @(negedge clk);
      idle();
      drive(0, 1'b1, 1'b0, 4, 32'd0);
      #1;
      check("rstmid_accept_m", 32'(m_ready), 32'd1);
      @(negedge clk);
      idle();
      rst_n = 1'b0;
      #1;
      check("rstmid_valid0_l", 32'(l_rsp_valid), 32'd0);
      check("rstmid_valid0_m", 32'(m_rsp_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rstmid_valid1_l", 32'(l_rsp_valid), 32'd0);
      check("rstmid_valid1_m", 32'(m_rsp_valid), 32'd0);
      @(negedge clk); #1;
      check("rstmid_valid2_m", 32'(m_rsp_valid), 32'd0);
      @(negedge clk);
      drive(0, 1'b1, 1'b0, 4, 32'd0);
      drive(1, 1'b1, 1'b0, 8, 32'd0);
      #1;
      check("rstmid_pointer_l", 32'(l_ready), 32'd1);
      check("rstmid_pointer_m", 32'(m_ready), 32'd1);
      @(negedge clk);
      idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
